alu_uart_interface: RTL

Byte-stream front end for the ALU, replacing switch/button/LED operand entry with a UART link. Takes received bytes from a UART receiver in the order A, B, OP, and evaluates them on an internal ALU instance. It then hands the 8-bit result to a UART transmitter through a start/done handshake. Sits between uart_rx/uart_tx and the ALU in the UART top level.

---
 rtl/alu_uart_interface_pkg.sv | 22 ++
 rtl/alu_uart_interface_alu.sv | 34 +++
 rtl/alu_uart_interface.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_uart_interface_pkg.sv
// Opcodes and frame-FSM state encoding shared by the ALU, the UART front end
// and the switch-based top.
package alu_uart_interface_pkg;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_SEND,
        S_WAIT_TX
    } state_t;

endpackage

// File: rtl/alu_uart_interface_alu.sv
// Combinational ALU on signed two's-complement operands; the result wraps to
// NB_DATA bits and unknown opcodes yield zero.
module alu_uart_interface_alu
    import alu_uart_interface_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    input  logic [NB_OP-1:0]   i_op,
    output logic [NB_DATA-1:0] o_result
);

    logic [5:0] op_code;

    assign op_code = 6'(i_op);

    always_comb begin
        o_result = '0;
        case (op_code)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_NOR:  o_result = ~(i_a | i_b);
            OP_SRA:  o_result = $signed(i_a) >>> i_b;
            OP_SRL:  o_result = i_a >> i_b;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_uart_interface.sv
// UART byte-stream front end: collects A, B, OP from the receiver, evaluates
// them on the ALU and hands the result to the transmitter via start/done.
//
// state     | meaning
// S_WAIT_A  | idle, next received byte is operand A
// S_WAIT_B  | waiting for operand B (timeout armed)
// S_WAIT_OP | waiting for opcode byte (timeout armed)
// S_SEND    | o_tx_start pulse, result already in o_tx_data
// S_WAIT_TX | holding o_tx_data until the transmitter reports done
module alu_uart_interface
    import alu_uart_interface_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_overrun,
    output logic               o_timeout
);

    localparam int              CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] a_q, a_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               overrun_q, overrun_d;
    logic               timeout_q, timeout_d;
    logic [NB_OP-1:0]   alu_op;
    logic [NB_DATA-1:0] alu_result;

    // The opcode byte feeds the ALU directly while it is being accepted so the
    // result is registered on the same edge and is valid during the start pulse.
    assign alu_op = (state_q == S_WAIT_OP) ? i_rx_data[NB_OP-1:0] : op_q;

    alu_uart_interface_alu #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_alu (
        .i_a      (a_q),
        .i_b      (b_q),
        .i_op     (alu_op),
        .o_result (alu_result)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_WAIT_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        cnt_d     = '0;
        tx_data_d = tx_data_q;
        overrun_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_WAIT_A: begin
                if (i_rx_done) begin
                    a_d     = i_rx_data;
                    state_d = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (i_rx_done) begin
                    b_d     = i_rx_data;
                    state_d = S_WAIT_OP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_WAIT_A;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_OP: begin
                if (i_rx_done) begin
                    op_d      = i_rx_data[NB_OP-1:0];
                    tx_data_d = alu_result;
                    state_d   = S_SEND;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_WAIT_A;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                overrun_d = i_rx_done;
                state_d   = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                overrun_d = i_rx_done;
                if (i_tx_done) begin
                    state_d = S_WAIT_A;
                end
            end
            default: state_d = S_WAIT_A;
        endcase
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_start = (state_q == S_SEND);
    assign o_busy     = (state_q == S_SEND) || (state_q == S_WAIT_TX);
    assign o_overrun  = overrun_q;
    assign o_timeout  = timeout_q;

endmodule
